// File: rtl/ul_sched_pkg.sv
// -----------------------------------------------------------------------------
// ul_sched_pkg
// Shared types and constants for the uplink compress packet scheduler.
//   sched_state_t : scheduler FSM states (idle, grant, send, inter-packet gap)
//   ul_hdr_t      : per-packet header {slot, symb, prb, rbg}, 24 bits packed
//   HDR_W         : header width in bits
// -----------------------------------------------------------------------------
package ul_sched_pkg;

  localparam int HDR_W = 24;

  // Prefixed literals keep the gap state distinct from the GAP length parameter
  // of the scheduler that imports this package.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_SEND  = 2'd2,
    S_GAP   = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [6:0] slot;
    logic [3:0] symb;
    logic [8:0] prb;
    logic [3:0] rbg;
  } ul_hdr_t;

endpackage : ul_sched_pkg

// File: rtl/rr_arbiter_oh.sv
// -----------------------------------------------------------------------------
// rr_arbiter_oh
// Combinational one-hot round-robin pick. The winner is the first set bit of
// req_i at or after ptr_i, wrapping modulo N.
// Ports:
//   req_i  [N-1:0]  request vector
//   ptr_i  [IW-1:0] priority pointer (index searched first)
//   gnt_o  [N-1:0]  one-hot grant (all zero when req_i is zero)
//   idx_o  [IW-1:0] index of the granted bit (zero when nothing is granted)
// -----------------------------------------------------------------------------
module rr_arbiter_oh #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0]  gnt_s;
  logic [IW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;
  int            pos_s;

  // Rotating scan from the pointer; the first hit locks out later positions.
  always_comb begin
    gnt_s   = {N{1'b0}};
    idx_s   = {IW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    pos_s   = 0;
    for (int i = 0; i < N; i++) begin
      pos_s        = int'(ptr_i) + i;
      pos_s        = (pos_s >= N) ? (pos_s - N) : pos_s;
      hit_s        = req_i[pos_s] & ~found_s;
      gnt_s[pos_s] = hit_s;
      idx_s        = hit_s ? IW'(pos_s) : idx_s;
      found_s      = found_s | hit_s;
    end
  end

  assign gnt_o = gnt_s;
  assign idx_o = idx_s;

endmodule : rr_arbiter_oh

// File: rtl/ul_compress_sched.sv
// -----------------------------------------------------------------------------
// ul_compress_sched
// Round-robin packet scheduler in front of the uplink compress datapath.
// Grants one of NUM_SRC sources at a time, frames a PKT_LEN-beat packet with
// sop/vld/eop, latches the winner's header, forces GAP idle cycles after each
// eop and limits packets in flight to MAX_OUT with a credit counter.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_enable        allows new grants (a packet in progress always completes)
//   i_req           per-source packet-ready levels
//   i_hdr           per-source headers, source 0 in bits [23:0]
//   i_credit_ret    one-cycle pulse per packet consumed downstream
//   o_gnt / o_src   one-hot grant and granted index, held for the packet
//   o_rd_en         read strobe to the granted buffer (same as o_vld)
//   o_sop/o_vld/o_eop  packet framing
//   o_*_idx         header latched at grant time
//   o_credit        credits available; o_credit_err sticky overflow flag
//   o_busy          FSM not idle
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module ul_compress_sched
  import ul_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PKT_LEN = 48,
  parameter int GAP     = 2,
  parameter int MAX_OUT = 4,
  parameter int CW      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic [NUM_SRC-1:0]       i_req,
  input  logic [NUM_SRC*HDR_W-1:0] i_hdr,
  input  logic                     i_credit_ret,
  output logic [NUM_SRC-1:0]       o_gnt,
  output logic                     o_rd_en,
  output logic [1:0]               o_src,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic                     o_vld,
  output logic [6:0]               o_slot_idx,
  output logic [3:0]               o_symb_idx,
  output logic [8:0]               o_prb_idx,
  output logic [3:0]               o_rbg_idx,
  output logic [CW-1:0]            o_credit,
  output logic                     o_busy,
  output logic                     o_credit_err
);

  localparam int            GW         = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [9:0]    BEAT_LAST  = 10'(PKT_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUT);
  localparam logic [1:0]    SRC_LAST   = 2'(NUM_SRC - 1);

  sched_state_t       state_q,  state_d;
  logic [9:0]         beat_q,   beat_d;
  logic [GW-1:0]      gap_q,    gap_d;
  logic [1:0]         ptr_q,    ptr_d;
  logic [NUM_SRC-1:0] gnt_q,    gnt_d;
  logic [1:0]         src_q,    src_d;
  ul_hdr_t            hdr_q,    hdr_d;
  logic               sop_q,    sop_d;
  logic               vld_q,    vld_d;
  logic               eop_q,    eop_d;
  logic               busy_q,   busy_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic               cerr_q,   cerr_d;

  logic [NUM_SRC-1:0] arb_gnt_s;
  logic [1:0]         arb_idx_s;
  ul_hdr_t            win_hdr_s;
  logic               grant_ok_s;

  rr_arbiter_oh #(
    .N  (NUM_SRC),
    .IW (2)
  ) u_arb (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s)
  );

  assign win_hdr_s  = ul_hdr_t'(i_hdr[int'(arb_idx_s)*HDR_W +: HDR_W]);
  // Credit is only ever checked in IDLE, so at most one packet per credit.
  assign grant_ok_s = i_enable & (|i_req) & (credit_q != {CW{1'b0}});

  // FSM next state, framing, grant and header capture.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    src_d   = src_q;
    hdr_d   = hdr_q;
    sop_d   = 1'b0;
    vld_d   = 1'b0;
    eop_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_ok_s) begin
          state_d = S_GRANT;
          gnt_d   = arb_gnt_s;
          src_d   = arb_idx_s;
          hdr_d   = win_hdr_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // PKT_LEN >= 2, so the first beat is never also the last one.
        state_d = S_SEND;
        beat_d  = 10'd0;
        sop_d   = 1'b1;
        vld_d   = 1'b1;
        eop_d   = 1'b0;
      end
      S_SEND: begin
        if (beat_q == BEAT_LAST) begin
          gnt_d   = {NUM_SRC{1'b0}};
          ptr_d   = (src_q == SRC_LAST) ? 2'd0 : (src_q + 2'd1);
          beat_d  = 10'd0;
          gap_d   = {GW{1'b0}};
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          beat_d = beat_q + 10'd1;
          vld_d  = 1'b1;
          eop_d  = ((beat_q + 10'd1) == BEAT_LAST);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = {GW{1'b0}};
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = {NUM_SRC{1'b0}};
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Credit counter: sop consumes, return replenishes, overflow is flagged.
  always_comb begin
    credit_d = credit_q;
    cerr_d   = cerr_q;
    if (sop_q && !i_credit_ret) begin
      credit_d = credit_q - CW'(1);
    end else if (!sop_q && i_credit_ret) begin
      if (credit_q == CREDIT_MAX) begin
        cerr_d = 1'b1;
      end else begin
        credit_d = credit_q + CW'(1);
      end
    end else begin
      credit_d = credit_q;
    end
  end

  // State and output registers; reset aborts any packet without an eop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      beat_q   <= 10'd0;
      gap_q    <= {GW{1'b0}};
      ptr_q    <= 2'd0;
      gnt_q    <= {NUM_SRC{1'b0}};
      src_q    <= 2'd0;
      hdr_q    <= ul_hdr_t'(24'd0);
      sop_q    <= 1'b0;
      vld_q    <= 1'b0;
      eop_q    <= 1'b0;
      busy_q   <= 1'b0;
      credit_q <= CREDIT_MAX;
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      src_q    <= src_d;
      hdr_q    <= hdr_d;
      sop_q    <= sop_d;
      vld_q    <= vld_d;
      eop_q    <= eop_d;
      busy_q   <= busy_d;
      credit_q <= credit_d;
      cerr_q   <= cerr_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_src        = src_q;
  assign o_sop        = sop_q;
  assign o_vld        = vld_q;
  assign o_rd_en      = vld_q;
  assign o_eop        = eop_q;
  assign o_slot_idx   = hdr_q.slot;
  assign o_symb_idx   = hdr_q.symb;
  assign o_prb_idx    = hdr_q.prb;
  assign o_rbg_idx    = hdr_q.rbg;
  assign o_credit     = credit_q;
  assign o_busy       = busy_q;
  assign o_credit_err = cerr_q;

endmodule : ul_compress_sched

// File: tb/tb_ul_compress_sched.sv
// -----------------------------------------------------------------------------
// tb_ul_compress_sched
// Directed scenarios plus randomized traffic for ul_compress_sched. The
// reference model tracks a packet as a single position counter over its
// lifetime (grant, PKT_LEN beats, GAP idle cycles) plus a credit tally.
// -----------------------------------------------------------------------------
module tb_ul_compress_sched;

  localparam int N  = 4;
  localparam int PL = 48;
  localparam int GP = 2;
  localparam int MO = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_enable;
  logic [N-1:0]    i_req;
  logic [N*24-1:0] i_hdr;
  logic            i_credit_ret;
  logic [N-1:0]    o_gnt;
  logic            o_rd_en;
  logic [1:0]      o_src;
  logic            o_sop, o_eop, o_vld;
  logic [6:0]      o_slot_idx;
  logic [3:0]      o_symb_idx;
  logic [8:0]      o_prb_idx;
  logic [3:0]      o_rbg_idx;
  logic [CW-1:0]   o_credit;
  logic            o_busy;
  logic            o_credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  ul_compress_sched #(
    .NUM_SRC(N), .PKT_LEN(PL), .GAP(GP), .MAX_OUT(MO), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_req(i_req), .i_hdr(i_hdr),
    .i_credit_ret(i_credit_ret), .o_gnt(o_gnt), .o_rd_en(o_rd_en), .o_src(o_src),
    .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld), .o_slot_idx(o_slot_idx),
    .o_symb_idx(o_symb_idx), .o_prb_idx(o_prb_idx), .o_rbg_idx(o_rbg_idx),
    .o_credit(o_credit), .o_busy(o_busy), .o_credit_err(o_credit_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_t: 0 = grant cycle, 1..PL = data beats, PL+1..PL+GP = forced gap.
  bit          m_act;
  int          m_t, m_win, m_ptr, m_credit;
  bit          m_err;
  logic [23:0] m_hdr;

  task automatic model_reset();
    m_act = 0; m_t = 0; m_win = 0; m_ptr = 0; m_credit = MO; m_err = 0; m_hdr = 24'd0;
  endtask

  task automatic model_step();
    bit sop_now;
    int w;
    if (!rst) begin
      model_reset();
      return;
    end
    sop_now = m_act && (m_t == 1);
    if (m_act) begin
      if (m_t == PL) m_ptr = (m_win + 1) % N;
      if (m_t == PL + GP) m_act = 0;
      else m_t++;
    end else if (i_enable && (i_req != 0) && (m_credit > 0)) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && i_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_win = w; m_act = 1; m_t = 0; m_hdr = i_hdr[w*24 +: 24];
    end
    if (sop_now && !i_credit_ret) m_credit--;
    else if (!sop_now && i_credit_ret) begin
      if (m_credit == MO) m_err = 1;
      else m_credit++;
    end
  endtask

  function automatic logic [N-1:0] e_gnt();
    return (m_act && m_t <= PL) ? N'(1 << m_win) : {N{1'b0}};
  endfunction
  function automatic logic e_sop(); return m_act && (m_t == 1); endfunction
  function automatic logic e_vld(); return m_act && (m_t >= 1) && (m_t <= PL); endfunction
  function automatic logic e_eop(); return m_act && (m_t == PL); endfunction

  function automatic logic [N*24-1:0] rand_hdr();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: advance the model on the inputs the DUT is about to sample.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; i_enable = 1'b0; i_req = 4'b0000; i_credit_ret = 1'b0; i_hdr = rand_hdr();
    cyc(); cyc();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; i_enable = 1'b1; i_req = 4'hF; i_credit_ret = 1'b0; i_hdr = rand_hdr();
    cyc(); cyc();
    n_checks++;
    if (o_credit !== 3'd4) begin
      n_fail++; $display("FAIL reset_credit: got %0d expected 4", o_credit);
    end
    n_checks++;
    if ({o_gnt, o_rd_en, o_src, o_sop, o_eop, o_vld, o_slot_idx, o_symb_idx,
         o_prb_idx, o_rbg_idx, o_busy, o_credit_err} !== 44'd0) begin
      n_fail++; $display("FAIL reset_outputs: gnt=%b sop=%b vld=%b busy=%b err=%b expected all 0",
                         o_gnt, o_sop, o_vld, o_busy, o_credit_err);
    end
    rst = 1'b1; i_enable = 1'b0; i_req = 4'b0000;
  endtask

  task automatic test_single();
    int lat, beats, eop_beat, hdr_bad;
    apply_reset();
    i_hdr = rand_hdr();
    i_hdr[23:0] = {7'd5, 4'($urandom), 9'd100, 4'($urandom)};
    i_req = 4'b0001; i_enable = 1'b1;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      cyc();
      if (c == 1) i_req = 4'b0000;   // dropped after sampling, grant still committed
      if (o_sop === 1'b1) lat = c;
    end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
    n_checks++;
    if (o_credit !== 3'd4) begin n_fail++; $display("FAIL single_credit_at_sop: got %0d expected 4", o_credit); end
    n_checks++;
    if (o_gnt !== 4'b0001 || o_src !== 2'd0) begin
      n_fail++; $display("FAIL single_grant: gnt=%b src=%0d expected 0001/0", o_gnt, o_src);
    end
    beats = 0; eop_beat = 0; hdr_bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (o_vld) begin
        beats++;
        if (o_eop) eop_beat = beats;
        if (o_prb_idx !== 9'd100 || o_slot_idx !== 7'd5) hdr_bad++;
      end
      if (c == 1) begin
        n_checks++;
        if (o_credit !== 3'd3) begin n_fail++; $display("FAIL single_credit_after_sop: got %0d expected 3", o_credit); end
      end
      cyc();
    end
    n_checks++;
    if (beats !== PL) begin n_fail++; $display("FAIL single_beats: got %0d expected %0d", beats, PL); end
    n_checks++;
    if (eop_beat !== PL) begin n_fail++; $display("FAIL single_eop_beat: got %0d expected %0d", eop_beat, PL); end
    n_checks++;
    if (hdr_bad !== 0) begin n_fail++; $display("FAIL single_hdr_hold: %0d bad beats expected 0", hdr_bad); end
    n_checks++;
    if (o_busy !== 1'b0 || o_gnt !== 4'b0000) begin
      n_fail++; $display("FAIL single_idle_after: busy=%b gnt=%b expected 0/0000", o_busy, o_gnt);
    end
  endtask

  task automatic test_round_robin();
    int sops, cycle, last_eop;
    bit ret_next;
    apply_reset();
    i_req = 4'hF; i_enable = 1'b1;
    sops = 0; cycle = 0; last_eop = -1; ret_next = 0;
    for (int c = 0; c < 400 && sops < 5; c++) begin
      cyc(); cycle++;
      i_credit_ret = ret_next; ret_next = 0;
      if (o_sop) begin
        n_checks++;
        if (o_gnt !== N'(1 << (sops % N))) begin
          n_fail++; $display("FAIL rr_order: packet %0d gnt=%b expected %b", sops, o_gnt, N'(1 << (sops % N)));
        end
        if (last_eop >= 0) begin
          n_checks++;
          if (cycle - last_eop !== GP + 3) begin
            n_fail++; $display("FAIL rr_gap: eop-to-sop %0d cycles expected %0d", cycle - last_eop, GP + 3);
          end
        end
        sops++;
        if (sops <= 3) ret_next = 1;
        if (sops == 5) i_req = 4'b0000;
      end
      if (o_eop) last_eop = cycle;
    end
    n_checks++;
    if (sops !== 5) begin n_fail++; $display("FAIL rr_count: got %0d sops expected 5", sops); end
    cyc(); cyc();
    n_checks++;
    if (o_credit !== 3'd2) begin n_fail++; $display("FAIL rr_credit: got %0d expected 2", o_credit); end
    for (int c = 0; c < 60; c++) cyc();
  endtask

  task automatic test_credit_exhaust();
    int sops;
    apply_reset();
    i_req = 4'hF; i_enable = 1'b1; sops = 0;
    for (int c = 0; c < 280; c++) begin cyc(); if (o_sop) sops++; end
    n_checks++;
    if (sops !== MO) begin n_fail++; $display("FAIL exhaust_count: got %0d expected %0d", sops, MO); end
    n_checks++;
    if (o_credit !== 3'd0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL exhaust_state: credit=%0d busy=%b expected 0/0", o_credit, o_busy);
    end
    i_credit_ret = 1'b1; cyc(); i_credit_ret = 1'b0;
    sops = 0;
    for (int c = 0; c < 80; c++) begin cyc(); if (o_sop) sops++; end
    n_checks++;
    if (sops !== 1 || o_credit !== 3'd0) begin
      n_fail++; $display("FAIL exhaust_release: sops=%0d credit=%0d expected 1/0", sops, o_credit);
    end
    i_req = 4'b0000;
  endtask

  task automatic test_credit_collide();
    int sops;
    apply_reset();
    i_req = 4'b0001; i_enable = 1'b1; sops = 0;
    for (int c = 0; c < 300 && sops < 3; c++) begin cyc(); if (o_sop) sops++; end
    n_checks++;
    if (sops !== 3 || o_credit !== 3'd2) begin
      n_fail++; $display("FAIL collide_setup: sops=%0d credit=%0d expected 3/2", sops, o_credit);
    end
    i_credit_ret = 1'b1; cyc(); i_credit_ret = 1'b0;
    n_checks++;
    if (o_credit !== 3'd2) begin n_fail++; $display("FAIL collide_credit: got %0d expected 2", o_credit); end
    i_req = 4'b0000;
    for (int c = 0; c < 60; c++) cyc();
    i_credit_ret = 1'b1; cyc(); cyc();
    n_checks++;
    if (o_credit !== 3'd4 || o_credit_err !== 1'b0) begin
      n_fail++; $display("FAIL collide_refill: credit=%0d err=%b expected 4/0", o_credit, o_credit_err);
    end
    cyc(); i_credit_ret = 1'b0;
    n_checks++;
    if (o_credit !== 3'd4 || o_credit_err !== 1'b1) begin
      n_fail++; $display("FAIL overflow: credit=%0d err=%b expected 4/1", o_credit, o_credit_err);
    end
    i_req = 4'b0001; cyc(); i_req = 4'b0000;
    for (int c = 0; c < 60; c++) cyc();
    n_checks++;
    if (o_credit_err !== 1'b1 || o_credit !== 3'd3) begin
      n_fail++; $display("FAIL overflow_sticky: err=%b credit=%0d expected 1/3", o_credit_err, o_credit);
    end
  endtask

  task automatic test_enable_drop();
    int beats, eop_beat, extra;
    bit found, dropped;
    apply_reset();
    i_req = 4'hF; i_enable = 1'b1; found = 0;
    for (int c = 0; c < 8 && !found; c++) begin cyc(); if (o_sop) found = 1; end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL en_sop_timeout: no sop within 8 cycles expected one"); end
    beats = 1; eop_beat = 0; extra = 0; dropped = 0;
    for (int c = 0; c < 160; c++) begin
      cyc();
      if (o_vld) beats++;
      if (!dropped && beats == 10) begin i_enable = 1'b0; dropped = 1; end
      if (o_eop) eop_beat = beats;
      if (o_sop) extra++;
    end
    n_checks++;
    if (eop_beat !== PL || beats !== PL) begin
      n_fail++; $display("FAIL en_complete: eop at beat %0d of %0d expected %0d", eop_beat, beats, PL);
    end
    n_checks++;
    if (extra !== 0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL en_blocked: extra sops=%0d busy=%b expected 0/0", extra, o_busy);
    end
    i_req = 4'b0000;
  endtask

  task automatic test_async_reset();
    int beats;
    bit found;
    apply_reset();
    i_req = 4'hF; i_enable = 1'b1; found = 0;
    for (int c = 0; c < 8 && !found; c++) begin cyc(); if (o_sop) found = 1; end
    beats = 1;
    for (int c = 0; c < 40 && beats < 20; c++) begin cyc(); if (o_vld) beats++; end
    #2; rst = 1'b0; #1;
    model_reset();
    n_checks++;
    if ({o_gnt, o_rd_en, o_src, o_sop, o_eop, o_vld, o_slot_idx, o_symb_idx,
         o_prb_idx, o_rbg_idx, o_busy, o_credit_err} !== 44'd0 || o_credit !== 3'd4) begin
      n_fail++; $display("FAIL async_reset: gnt=%b vld=%b eop=%b busy=%b credit=%0d expected zeros and 4",
                         o_gnt, o_vld, o_eop, o_busy, o_credit);
    end
    i_req = 4'b0100; cyc(); rst = 1'b1;
    found = 0;
    for (int c = 0; c < 5 && !found; c++) begin cyc(); if (o_gnt != 4'b0000) found = 1; end
    n_checks++;
    if (o_gnt !== 4'b0100 || o_src !== 2'd2) begin
      n_fail++; $display("FAIL reset_regrant: gnt=%b src=%0d expected 0100/2", o_gnt, o_src);
    end
    i_req = 4'b0000;
    for (int c = 0; c < 60; c++) cyc();
  endtask

  task automatic test_random_traffic();
    int errs;
    apply_reset();
    errs = 0;
    for (int c = 0; c < 2000 && errs < 20; c++) begin
      i_enable     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) i_req = 4'($urandom);
      i_credit_ret = ($urandom_range(0, 19) == 0);
      i_hdr        = rand_hdr();
      cyc();
      n_checks++;
      if (o_gnt !== e_gnt() || o_sop !== e_sop() || o_vld !== e_vld() ||
          o_eop !== e_eop() || o_rd_en !== e_vld() || o_busy !== m_act) begin
        n_fail++; errs++;
        $display("FAIL rand_framing cyc %0d: gnt=%b sop=%b vld=%b eop=%b rd=%b busy=%b expected %b %b %b %b %b %b",
                 c, o_gnt, o_sop, o_vld, o_eop, o_rd_en, o_busy,
                 e_gnt(), e_sop(), e_vld(), e_eop(), e_vld(), m_act);
      end
      n_checks++;
      if (o_src !== 2'(m_win) || {o_slot_idx, o_symb_idx, o_prb_idx, o_rbg_idx} !== m_hdr) begin
        n_fail++; errs++;
        $display("FAIL rand_header cyc %0d: src=%0d hdr=%h expected %0d %h", c, o_src,
                 {o_slot_idx, o_symb_idx, o_prb_idx, o_rbg_idx}, m_win, m_hdr);
      end
      n_checks++;
      if (o_credit !== CW'(m_credit) || o_credit_err !== m_err) begin
        n_fail++; errs++;
        $display("FAIL rand_credit cyc %0d: credit=%0d err=%b expected %0d %b", c, o_credit, o_credit_err, m_credit, m_err);
      end
    end
    i_req = 4'b0000; i_credit_ret = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_enable = 1'b0; i_req = 4'b0000; i_credit_ret = 1'b0; i_hdr = {(N*24){1'b0}};
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_credit_exhaust();
    test_credit_collide();
    test_enable_drop();
    test_async_reset();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ul_compress_sched

// File: doc/ul_compress_sched.md
Name: ul_compress_sched

Overview:
- Round-robin packet scheduler in front of the uplink compress datapath (4-lane 32-bit IQ in, 14-bit compressed out, 19-cycle pipeline).
- Arbitrates among NUM_SRC per-cell PRB-group buffers and grants one source at a time.
- Generates the sop/vld/eop framing and the header fields (slot/symb/prb/rbg) for the granted packet.
- Throttles issue with a credit counter so that no more than MAX_OUT packets are in flight between issue and downstream consumption.

Parameters:
- NUM_SRC, 4: number of requesting sources.
- PKT_LEN, 48: vld cycles per packet (4 PRB x 12 RE); must be >= 2.
- GAP, 2: idle cycles forced after each eop; 0 is legal.
- MAX_OUT, 4: credit pool size (packets in flight).
- CW, 3: credit counter width; must be >= clog2(MAX_OUT+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  scheduler enable.
- i_req  in  NUM_SRC  per-source packet-ready level.
- i_hdr  in  NUM_SRC*24  per-source header {slot[6:0], symb[3:0], prb[8:0], rbg[3:0]}; source 0 in bits [23:0].
- i_credit_ret  in  1  single-cycle pulse, one packet consumed downstream.
- o_gnt  out  NUM_SRC  one-hot grant; held for the whole packet.
- o_rd_en  out  1  read strobe to the granted source buffer; equal to o_vld.
- o_src  out  2  index of the granted source.
- o_sop  out  1  start of packet.
- o_eop  out  1  end of packet.
- o_vld  out  1  data valid.
- o_slot_idx  out  7  latched header field.
- o_symb_idx  out  4  latched header field.
- o_prb_idx  out  9  latched header field.
- o_rbg_idx  out  4  latched header field.
- o_credit  out  CW  credits currently available.
- o_busy  out  1  high in any state other than IDLE.
- o_credit_err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE and the round-robin pointer goes to 0.
  - Credit counter goes to MAX_OUT.
  - Every other output goes to 0. o_credit therefore reads MAX_OUT during reset.
  - Reset mid-packet aborts the packet immediately. No eop is emitted.
- FSM states: IDLE, GRANT, SEND, GAP.
- IDLE -> GRANT at the first edge where all of these hold: i_enable=1, i_req!=0, credit>0.
  - Winner is the first set bit of i_req at or after the pointer, wrapping modulo NUM_SRC.
  - On the same edge: o_gnt/o_src are registered and the winner's i_hdr is latched into o_*_idx.
  - Header outputs are stable from GRANT through eop.
- GRANT -> SEND after 1 cycle.
  - o_sop=o_vld=o_rd_en=1 in the first SEND cycle.
  - Latency: 2 clocks from the req-sampling edge to sop.
- SEND lasts exactly PKT_LEN cycles.
  - o_vld=1 on every cycle; o_eop=1 on the last cycle.
  - A 10-bit beat counter counts these cycles.
  - i_req and i_enable are ignored during SEND; a packet is never truncated.
- Leaving SEND after eop:
  - The pointer advances to winner+1 mod NUM_SRC.
  - o_gnt clears.
  - Next state is GAP if GAP>0, otherwise IDLE.
- GAP lasts GAP cycles, then the FSM returns to IDLE.
  - A further grant therefore takes at least 1 IDLE cycle + 1 GRANT cycle.
- Credits:
  - Decrement by 1 on the sop cycle; increment by 1 on i_credit_ret.
  - Simultaneous sop and return leaves the count unchanged.
  - A return while count==MAX_OUT (with no sop that cycle) leaves the count at MAX_OUT and sets o_credit_err. o_credit_err clears only on reset.
  - Underflow cannot occur, because a grant requires credit>0.
- A source dropping i_req between sampling and sop is still served (the grant is committed); the source buffer is responsible for it.
- i_enable=0:
  - Only blocks the IDLE -> GRANT transition.
  - A packet in progress completes, including GAP.
- o_busy = (state != IDLE).

Decomposition:
- Package ul_sched_pkg holds:
  - typedef sched_state_t {IDLE, GRANT, SEND, GAP};
  - typedef ul_hdr_t as a packed struct {slot, symb, prb, rbg} (24 bits);
  - constant HDR_W = 24.
- One sub-module, rr_arbiter_oh: combinational one-hot round-robin pick, with inputs req/pointer and outputs gnt/idx.
- The credit counter stays inline.

Test Plan:
- Single source: i_req=4'b0001, hdr slot=5, prb=100 → sop 2 clocks after the sample edge, 48 vld, eop on beat 48, o_prb_idx=100 throughout, o_credit 4→3.
- All four sources requesting, 3 returns pulsed meanwhile → grants in order 0,1,2,3,0.
  - Gap of exactly 2 + 2 cycles between one eop and the next sop.
- No credit returns with i_req=4'hF → exactly 4 packets issued, o_credit=0, o_busy low.
  - A single i_credit_ret pulse releases exactly one more packet.
- i_credit_ret pulsed on a sop cycle at credit=2 → o_credit stays 2. Extra return at credit=4 → o_credit=4 and o_credit_err=1 (sticky).
- i_enable dropped on beat 10 → packet still ends with eop at beat 48. No new sop while i_enable=0, even with i_req=4'hF.
- rst asserted on beat 20 → all outputs 0 asynchronously and o_credit=4. After release with i_req=4'b0100, the first grant goes to source 2 (pointer reset to 0).
